// File: rtl/fp_result_checker_if.sv
// Result/compare bundle for the lockstep checker: per-channel result strobes in,
// one compared set out.
interface fp_result_checker_if #(
    parameter int SIZE = 32,
    parameter int CH   = 2
);
    logic [CH-1:0]      res_rdy;
    logic [CH*SIZE-1:0] res;
    logic               cmp_valid;
    logic               cmp_match;
    logic [SIZE-1:0]    cmp_res;
    logic [CH-1:0]      cmp_mask;

    modport master (
        output res_rdy, res,
        input  cmp_valid, cmp_match, cmp_res, cmp_mask
    );

    modport slave (
        input  res_rdy, res,
        output cmp_valid, cmp_match, cmp_res, cmp_mask
    );
endinterface

// File: rtl/fp_result_checker.sv
// N-channel lockstep result checker: per-channel FIFOs absorb skew between cores,
// whole sets are popped together and compared against channel 0.
module fp_result_checker #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int CH      = 2,
    parameter int DEPTH   = 4,
    parameter int NAN_EQ  = 1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    fp_result_checker_if.slave bus,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             overflow,
    output logic             timeout,
    output logic             busy
);
    localparam int SIZE = 1 + EXP_W + MAN_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    logic [SIZE-1:0]  mem_q    [CH][DEPTH];
    logic [PW-1:0]    wr_ptr_q [CH];
    logic [PW-1:0]    rd_ptr_q [CH];
    logic [CW-1:0]    cnt_q    [CH];
    logic [CW-1:0]    cnt_d    [CH];
    logic [SIZE-1:0]  head     [CH];
    logic [CH-1:0]    wr_en;
    logic [CH-1:0]    drop;
    logic [CH-1:0]    mask_d;
    logic             pop;
    logic             nonempty_d;

    logic             cmp_valid_q;
    logic             cmp_match_q;
    logic [SIZE-1:0]  cmp_res_q;
    logic [CH-1:0]    cmp_mask_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic             overflow_q;
    logic             timeout_q;
    logic             busy_q;
    logic [TW-1:0]    to_cnt_q;
    logic [TW-1:0]    to_cnt_d;

    function automatic logic is_nan(input logic [SIZE-1:0] v);
        return (&v[SIZE-2 -: EXP_W]) && (|v[MAN_W-1:0]);
    endfunction

    always_comb begin
        pop = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (cnt_q[i] == '0) pop = 1'b0;
        end
    end

    // A full FIFO still accepts a write when its head leaves on the same edge.
    always_comb begin
        wr_en      = '0;
        drop       = '0;
        nonempty_d = 1'b0;
        for (int i = 0; i < CH; i++) begin
            head[i] = mem_q[i][rd_ptr_q[i]];
            if (bus.res_rdy[i]) begin
                if (cnt_q[i] == CW'(DEPTH) && !pop) drop[i]  = 1'b1;
                else                                 wr_en[i] = 1'b1;
            end
            cnt_d[i] = cnt_q[i] + CW'(wr_en[i]) - CW'(pop);
            if (cnt_d[i] != '0) nonempty_d = 1'b1;
        end
    end

    always_comb begin
        mask_d = '0;
        for (int i = 1; i < CH; i++) begin
            if ((head[i] != head[0]) &&
                !((NAN_EQ != 0) && is_nan(head[i]) && is_nan(head[0])))
                mask_d[i] = 1'b1;
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (pop || !busy_q)                 to_cnt_d = '0;
        else if (to_cnt_q != TW'(TIMEOUT))  to_cnt_d = to_cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= bus.res[i*SIZE +: SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            cmp_valid_q <= 1'b0;
            cmp_match_q <= 1'b0;
            cmp_res_q   <= '0;
            cmp_mask_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                if (pop)      rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
            busy_q      <= nonempty_d;
            cmp_valid_q <= pop;
            if (pop) begin
                cmp_match_q <= ~|mask_d;
                cmp_res_q   <= head[0];
                cmp_mask_q  <= mask_d;
            end
            // clr drops the statistics update of a coincident pop, not the pop itself.
            if (clr) begin
                pass_q     <= '0;
                fail_q     <= '0;
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
                to_cnt_q   <= '0;
            end else begin
                to_cnt_q <= to_cnt_d;
                if (to_cnt_d == TW'(TIMEOUT)) timeout_q  <= 1'b1;
                if (|drop)                    overflow_q <= 1'b1;
                if (pop) begin
                    if (~|mask_d) begin
                        if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.cmp_valid = cmp_valid_q;
    assign bus.cmp_match = cmp_match_q;
    assign bus.cmp_res   = cmp_res_q;
    assign bus.cmp_mask  = cmp_mask_q;
    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker; a NAN_EQ=0 twin sees the same stimulus.
module tb_fp_result_checker;
    localparam int SIZE = 32;
    localparam int CH   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  rdy_r = '0;
    logic [63:0] res_r = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    fp_result_checker_if #(.SIZE(SIZE), .CH(CH)) bus ();
    fp_result_checker_if #(.SIZE(SIZE), .CH(CH)) bus_n ();

    assign bus.res_rdy   = rdy_r;
    assign bus.res       = res_r;
    assign bus_n.res_rdy = rdy_r;
    assign bus_n.res     = res_r;

    logic [15:0] pass_a, fail_a, pass_b, fail_b;
    logic        ovf_a, to_a, busy_a, ovf_b, to_b, busy_b;

    fp_result_checker #(.NAN_EQ(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .overflow(ovf_a),
        .timeout(to_a), .busy(busy_a)
    );

    fp_result_checker #(.NAN_EQ(0)) dut_n (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus_n),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .overflow(ovf_b),
        .timeout(to_b), .busy(busy_b)
    );

    task automatic step(input logic [1:0] rdy, input logic [31:0] v0, input logic [31:0] v1);
        rdy_r = rdy;
        res_r = {v1, v0};
        @(posedge clk);
        #1;
        rdy_r = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2'b00, 32'h0, 32'h0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(2'b11, 32'h1234_5678, 32'h1234_5678);
        n_chk++; if (bus.cmp_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", bus.cmp_valid); else n_pass++;
        n_chk++; if (bus.cmp_match !== 1'b0) $display("FAIL reset_match got=%0h exp=0", bus.cmp_match); else n_pass++;
        n_chk++; if (bus.cmp_res !== 32'h0) $display("FAIL reset_res got=%h exp=0", bus.cmp_res); else n_pass++;
        n_chk++; if (bus.cmp_mask !== 2'b00) $display("FAIL reset_mask got=%b exp=00", bus.cmp_mask); else n_pass++;
        n_chk++; if ({pass_a, fail_a} !== 32'h0) $display("FAIL reset_cnt got=%h exp=0", {pass_a, fail_a}); else n_pass++;
        n_chk++; if ({ovf_a, to_a, busy_a} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {ovf_a, to_a, busy_a}); else n_pass++;
        rst = 1'b1;
        step(2'b01, 32'h4000_0000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 32'h0, 32'h0);
            n_chk++; if (bus.cmp_valid !== 1'b0) $display("FAIL reset_partial_valid got=%0h exp=0", bus.cmp_valid); else n_pass++;
        end
        n_chk++; if (busy_a !== 1'b1) $display("FAIL reset_partial_busy got=%0h exp=1", busy_a); else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        step(2'b10, 32'h0, 32'h4040_0000);
        step(2'b00, 32'h0, 32'h0);
        step(2'b00, 32'h0, 32'h0);
        step(2'b01, 32'h4040_0000, 32'h0);
        n_chk++; if (bus.cmp_valid !== 1'b0) $display("FAIL ooo_early_valid got=%0h exp=0", bus.cmp_valid); else n_pass++;
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if (bus.cmp_valid !== 1'b1) $display("FAIL ooo_valid got=%0h exp=1", bus.cmp_valid); else n_pass++;
        n_chk++; if (bus.cmp_match !== 1'b1) $display("FAIL ooo_match got=%0h exp=1", bus.cmp_match); else n_pass++;
        n_chk++; if (bus.cmp_res !== 32'h4040_0000) $display("FAIL ooo_res got=%h exp=40400000", bus.cmp_res); else n_pass++;
        n_chk++; if (bus.cmp_mask !== 2'b00) $display("FAIL ooo_mask got=%b exp=00", bus.cmp_mask); else n_pass++;
        n_chk++; if (pass_a !== 16'd1) $display("FAIL ooo_pass got=%0d exp=1", pass_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL ooo_busy got=%0h exp=0", busy_a); else n_pass++;
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if (bus.cmp_valid !== 1'b0) $display("FAIL ooo_valid_drop got=%0h exp=0", bus.cmp_valid); else n_pass++;
        n_chk++; if ({bus.cmp_match, bus.cmp_res} !== {1'b1, 32'h4040_0000}) $display("FAIL ooo_hold got=%h exp=140400000", {bus.cmp_match, bus.cmp_res}); else n_pass++;
    endtask

    task automatic test_mismatch_nan();
        step(2'b11, 32'h3F80_0000, 32'h3F80_0001);
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if ({bus.cmp_valid, bus.cmp_match} !== 2'b10) $display("FAIL mm_valid_match got=%b exp=10", {bus.cmp_valid, bus.cmp_match}); else n_pass++;
        n_chk++; if (bus.cmp_mask !== 2'b10) $display("FAIL mm_mask got=%b exp=10", bus.cmp_mask); else n_pass++;
        n_chk++; if (bus.cmp_res !== 32'h3F80_0000) $display("FAIL mm_res got=%h exp=3f800000", bus.cmp_res); else n_pass++;
        n_chk++; if (fail_a !== 16'd1) $display("FAIL mm_fail got=%0d exp=1", fail_a); else n_pass++;
        step(2'b11, 32'h7FC0_0000, 32'hFF80_0001);
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if ({bus.cmp_match, bus.cmp_mask} !== 3'b100) $display("FAIL nan_eq1 got=%b exp=100", {bus.cmp_match, bus.cmp_mask}); else n_pass++;
        n_chk++; if ({bus_n.cmp_match, bus_n.cmp_mask} !== 3'b010) $display("FAIL nan_eq0 got=%b exp=010", {bus_n.cmp_match, bus_n.cmp_mask}); else n_pass++;
        step(2'b11, 32'h0000_0000, 32'h8000_0000);
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if ({bus.cmp_valid, bus.cmp_match, bus.cmp_mask} !== 4'b1010) $display("FAIL zero_sign got=%b exp=1010", {bus.cmp_valid, bus.cmp_match, bus.cmp_mask}); else n_pass++;
        n_chk++; if ({pass_a, fail_a} !== {16'd2, 16'd2}) $display("FAIL mm_cnt_a got=%h exp=00020002", {pass_a, fail_a}); else n_pass++;
        n_chk++; if ({pass_b, fail_b} !== {16'd1, 16'd3}) $display("FAIL mm_cnt_b got=%h exp=00010003", {pass_b, fail_b}); else n_pass++;
    endtask

    task automatic test_burst_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(2'b01, 32'h4100_0000 + 32'(k), 32'h0);
            if (k == 3) begin
                n_chk++; if (ovf_a !== 1'b0) $display("FAIL burst_ovf_early got=%0h exp=0", ovf_a); else n_pass++;
            end
        end
        n_chk++; if (ovf_a !== 1'b1) $display("FAIL burst_ovf got=%0h exp=1", ovf_a); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(2'b10, 32'h0, 32'h4100_0000 + 32'(k));
            if (k > 0) begin
                n_chk++; if ({bus.cmp_valid, bus.cmp_match, bus.cmp_res} !== {2'b11, 32'h4100_0000 + 32'(k - 1)})
                    $display("FAIL burst_pop%0d got=%h exp=%h", k - 1, {bus.cmp_valid, bus.cmp_match, bus.cmp_res}, {2'b11, 32'h4100_0000 + 32'(k - 1)});
                else n_pass++;
            end
        end
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if ({bus.cmp_valid, bus.cmp_match, bus.cmp_res} !== {2'b11, 32'h4100_0003}) $display("FAIL burst_pop3 got=%h exp=341000003", {bus.cmp_valid, bus.cmp_match, bus.cmp_res}); else n_pass++;
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if (bus.cmp_valid !== 1'b0) $display("FAIL burst_tail_valid got=%0h exp=0", bus.cmp_valid); else n_pass++;
        n_chk++; if ({pass_a, fail_a} !== {16'd4, 16'd0}) $display("FAIL burst_cnt got=%h exp=00040000", {pass_a, fail_a}); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL burst_busy got=%0h exp=0", busy_a); else n_pass++;
    endtask

    task automatic test_timeout_clr();
        do_reset();
        step(2'b11, 32'h4248_0000, 32'h4248_0000);
        step(2'b00, 32'h0, 32'h0);
        step(2'b01, 32'h4280_0000, 32'h0);
        for (int k = 1; k < 5; k++) step(2'b01, 32'h4300_0000 + 32'(k), 32'h0);
        for (int k = 5; k < 64; k++) step(2'b00, 32'h0, 32'h0);
        n_chk++; if (to_a !== 1'b0) $display("FAIL to_early got=%0h exp=0", to_a); else n_pass++;
        step(2'b00, 32'h0, 32'h0);
        n_chk++; if (to_a !== 1'b1) $display("FAIL to_set got=%0h exp=1", to_a); else n_pass++;
        n_chk++; if ({ovf_a, pass_a} !== {1'b1, 16'd1}) $display("FAIL to_pre_clr got=%h exp=10001", {ovf_a, pass_a}); else n_pass++;
        clr = 1'b1;
        step(2'b00, 32'h0, 32'h0);
        clr = 1'b0;
        n_chk++; if ({to_a, ovf_a} !== 2'b00) $display("FAIL clr_flags got=%b exp=00", {to_a, ovf_a}); else n_pass++;
        n_chk++; if ({pass_a, fail_a} !== 32'h0) $display("FAIL clr_cnt got=%h exp=0", {pass_a, fail_a}); else n_pass++;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL clr_busy got=%0h exp=1", busy_a); else n_pass++;
        step(2'b10, 32'h0, 32'h4280_0000);
        clr = 1'b1;
        step(2'b00, 32'h0, 32'h0);
        clr = 1'b0;
        n_chk++; if ({bus.cmp_valid, bus.cmp_match} !== 2'b11) $display("FAIL clr_pop got=%b exp=11", {bus.cmp_valid, bus.cmp_match}); else n_pass++;
        n_chk++; if (pass_a !== 16'd0) $display("FAIL clr_pop_cnt got=%0d exp=0", pass_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        step(2'b01, 32'h4000_0001, 32'h0);
        step(2'b11, 32'h4000_0002, 32'h4000_0001);
        rst = 1'b0;
        step(2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        n_chk++; if ({busy_a, bus.cmp_valid} !== 2'b00) $display("FAIL rmid_busy_valid got=%b exp=00", {busy_a, bus.cmp_valid}); else n_pass++;
        n_chk++; if ({pass_a, fail_a} !== 32'h0) $display("FAIL rmid_cnt got=%h exp=0", {pass_a, fail_a}); else n_pass++;
        pulses = 0;
        step(2'b11, 32'h4500_0000, 32'h4500_0000);
        for (int k = 0; k < 4; k++) begin
            step(2'b00, 32'h0, 32'h0);
            if (bus.cmp_valid === 1'b1) pulses++;
            if (k == 0) begin
                n_chk++; if (bus.cmp_res !== 32'h4500_0000) $display("FAIL rmid_res got=%h exp=45000000", bus.cmp_res); else n_pass++;
            end
        end
        n_chk++; if (pulses !== 1) $display("FAIL rmid_pulses got=%0d exp=1", pulses); else n_pass++;
        n_chk++; if (pass_a !== 16'd1) $display("FAIL rmid_pass got=%0d exp=1", pass_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_out_of_order();
        test_mismatch_nan();
        test_burst_overflow();
        test_timeout_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_result_checker.md
Name: fp_result_checker

Overview:
- Hardware lockstep checker for the floating-point multiplier top level.
- Collects results from CH independent multiplier implementations (e.g. Verilog and VHDL cores), each of which may finish at a different cycle and in any order.
- Buffers each channel's results in its own FIFO, then pops one entry from every channel together and compares them.
- Keeps pass/fail statistics plus sticky error flags, replacing bench-side serialisation with a synthesizable, N-channel, NaN-aware checker.

Parameters:
- EXP_W, 8: exponent width.
- MAN_W, 23: mantissa width. Operand width SIZE = 1+EXP_W+MAN_W (32 by default).
- CH, 2: number of result channels (≥2).
- DEPTH, 4: per-channel FIFO depth (power of 2, ≥2).
- NAN_EQ, 1: 1 = any NaN equals any NaN; 0 = bitwise compare only.
- TIMEOUT, 64: cycles a partial set may wait before the timeout flag is raised.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- clr  in  1  synchronous clear of counters and sticky flags; FIFOs are untouched.
- res_rdy  in  CH  per-channel one-cycle result strobe.
- res  in  CH*SIZE  channel i result on res[i*SIZE +: SIZE].
- cmp_valid  out  1  one-cycle pulse: a comparison completed.
- cmp_match  out  1  all channels matched; valid while cmp_valid is high.
- cmp_res  out  SIZE  channel 0 value of the compared set.
- cmp_mask  out  CH  bit i set when channel i differs from channel 0; bit 0 is always 0.
- pass_cnt  out  CNT_W  matching comparisons.
- fail_cnt  out  CNT_W  mismatching comparisons.
- overflow  out  1  sticky: a write was dropped on a full FIFO.
- timeout  out  1  sticky: a partial set waited TIMEOUT cycles.
- busy  out  1  any FIFO non-empty.

Behaviour:
- Reset (rst=0 at an edge):
  - All FIFOs empty; pointers and counts are 0.
  - All outputs are 0.
  - Timeout counter is 0.
  - rst has priority over every other input.
- FIFO write: at each edge, channel i writes res[i] when res_rdy[i]=1.
  - Full and no pop in the same edge: the write is dropped and overflow is set.
  - Full with a pop in the same edge: the write is accepted; count stays at DEPTH.
  - Pointers wrap modulo DEPTH.
- Pop:
  - Pop condition = every FIFO non-empty, evaluated on registered state.
  - All heads are popped at the same edge.
  - Write and pop on the same channel in the same edge leaves its count unchanged.
- Latency:
  - The last-arriving result is sampled at edge E0.
  - The pop happens at E1.
  - cmp_valid, cmp_match, cmp_res and cmp_mask are registered at E1 and visible for exactly the one cycle after E1.
  - Back-to-back sets produce one cmp_valid per cycle.
- Compare:
  - mask[i] = (head_i != head_0).
  - With NAN_EQ=1, a pair where both values are NaN (exponent all ones, mantissa ≠ 0) is treated as equal, regardless of sign or payload.
  - Infinities and ±0 are compared bitwise, so +0 ≠ −0.
  - cmp_match = ~|mask.
- Outputs between comparisons: cmp_match, cmp_res and cmp_mask hold their last values; cmp_valid=0.
- Statistics:
  - On each pop, pass_cnt or fail_cnt increments by 1.
  - Both counters saturate at 2^CNT_W−1.
- Timeout:
  - The counter increments each cycle that busy=1 and no pop occurs.
  - It resets to 0 on a pop or when busy=0.
  - Reaching TIMEOUT sets timeout (sticky); the counter then holds.
- clr:
  - Zeroes pass_cnt, fail_cnt, overflow, timeout and the timeout counter.
  - A pop in the same cycle as clr is still performed, but its counter increment is lost (clr wins).
- busy: registered; equal to the OR of the FIFO non-empty flags after the current edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with strobes active → all outputs 0, busy=0; after release, nothing is emitted until both channels have written.
- Out-of-order match (CH=2):
  - Stimulus: ch1 writes 0x40400000 at edge 5; ch0 writes 0x40400000 at edge 8.
  - Response: cmp_valid high only in the cycle after edge 9, cmp_match=1, cmp_res=0x40400000, pass_cnt=1.
- Mismatch and NaN handling:
  - ch0=0x3F800000, ch1=0x3F800001 → cmp_match=0, cmp_mask=2'b10, fail_cnt=1.
  - ch0=0x7FC00000, ch1=0xFF800001 with NAN_EQ=1 → match. Same pair with NAN_EQ=0 → mismatch.
  - ch0=0x00000000, ch1=0x80000000 → mismatch.
- Burst and overflow (DEPTH=4):
  - Stimulus: ch0 writes 5 values on consecutive edges while ch1 is idle.
  - Response: 5th write dropped, overflow=1. Then ch1 writes 4 matching values → 4 consecutive cmp_valid pulses, pass_cnt=4, busy=0 afterwards.
- Timeout and clr:
  - Stimulus: ch0 writes once, ch1 stays silent for TIMEOUT=64 cycles.
  - Response: timeout=1 exactly 64 cycles after busy rose.
  - Then pulse clr → timeout, overflow and both counters read 0; the FIFO entry is retained (busy=1).
- Reset mid-operation: ch0 holds 2 entries and ch1 holds 1 when rst=0 is applied → next cycle busy=0 and the counters are 0; a subsequent matched pair produces exactly one cmp_valid.
